// File: rtl/uart_bram_loader.sv
// uart_bram_loader: receives 8N1 bytes on uart_rxd, packs them MSB-first into
// BRAM_WIDTH-bit words and issues one BRAM write per completed word, walking
// the address through one frame of BRAM_DEPTH words and wrapping.
module uart_bram_loader #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 3000000,
    parameter int BRAM_WIDTH = 48,
    parameter int BRAM_DEPTH = 12800,
    localparam int ADDR_W    = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  uart_rxd,
    input  logic                  clear_in,
    output logic [ADDR_W-1:0]     addr_out,
    output logic [BRAM_WIDTH-1:0] data_out,
    output logic                  we_out,
    output logic                  frame_done_out,
    output logic                  busy_out,
    output logic                  error_out
);

    localparam int CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int BYTES_PER_WORD = BRAM_WIDTH / 8;
    localparam int TMR_W          = $clog2(CLKS_PER_BIT + 1);
    localparam int CNT_W          = $clog2(BYTES_PER_WORD + 1);

    localparam logic [TMR_W-1:0]  HALF_END  = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0]  FULL_END  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BRAM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                  rx_meta_q, rx_sync_q, rx_s;
    state_t                state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            shift_q, shift_d;
    logic                  byte_ok_s, frame_err_s;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BRAM_WIDTH-1:0] word_q, word_d;
    logic [BRAM_WIDTH-1:0] data_q, data_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic                  fd_q, fd_d;
    logic                  err_q, err_d;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rxd;
            rx_sync_q <= rx_meta_q;
        end
    end

    assign rx_s = rx_sync_q;

    // Receiver and word-assembly state registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            cnt_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
        end
    end

    // Receiver FSM: mid-bit sampling; flags accepted bytes and framing errors.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TMR_W'(1);
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_ok_s   = 1'b0;
        frame_err_s = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (timer_q == HALF_END) begin
                    timer_d = '0;
                    bit_d   = 3'd0;
                    // A line that is high again at start-bit centre was noise.
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (timer_q == FULL_END) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (timer_q == FULL_END) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Word packing, write strobe, addressing and sticky error; clear_in wins.
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        data_d = data_q;
        we_d   = 1'b0;
        fd_d   = 1'b0;
        err_d  = err_q;
        if (we_q) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end else begin
            addr_d = addr_q;
        end
        if (clear_in) begin
            cnt_d  = '0;
            addr_d = '0;
            err_d  = 1'b0;
        end else begin
            if (frame_err_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            if (byte_ok_s) begin
                word_d = (word_q << 8) | BRAM_WIDTH'(shift_q);
                if (cnt_q == LAST_BYTE) begin
                    cnt_d  = '0;
                    data_d = (word_q << 8) | BRAM_WIDTH'(shift_q);
                    we_d   = 1'b1;
                    fd_d   = (addr_q == LAST_ADDR);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                word_d = word_q;
            end
        end
    end

    assign addr_out       = addr_q;
    assign data_out       = data_q;
    assign we_out         = we_q;
    assign frame_done_out = fd_q;
    assign error_out      = err_q;
    assign busy_out       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_bram_loader.sv
// Bench for uart_bram_loader: random 8N1 byte streams checked against a
// queue-based model of word packing, addressing, frame wrap and latency.
module tb_uart_bram_loader;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CPB   = 33;
    localparam int LAT   = 316;   // pin start edge to we_out, in cycles

    logic          clk_in   = 1'b0;
    logic          rst_in   = 1'b1;
    logic          uart_rxd = 1'b1;
    logic          clear_in = 1'b0;
    logic [AW-1:0] addr_out;
    logic [47:0]   data_out;
    logic          we_out;
    logic          frame_done_out;
    logic          busy_out;
    logic          error_out;

    uart_bram_loader #(
        .CLK_FREQ  (100000000),
        .BAUD_RATE (3000000),
        .BRAM_WIDTH(48),
        .BRAM_DEPTH(DEPTH)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .uart_rxd      (uart_rxd),
        .clear_in      (clear_in),
        .addr_out      (addr_out),
        .data_out      (data_out),
        .we_out        (we_out),
        .frame_done_out(frame_done_out),
        .busy_out      (busy_out),
        .error_out     (error_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pending bytes of the current word and the next address.
    typedef struct {
        int          addr;
        logic [47:0] data;
        bit          fd;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] pend_w = 48'h0;
    int          pend_n = 0;
    int          m_addr = 0;
    int          fd_seen = 0;

    task automatic model_accept(input logic [7:0] b, input int c0);
        exp_t e;
        pend_w = {pend_w[39:0], b};
        pend_n++;
        if (pend_n == 6) begin
            e.addr = m_addr;
            e.data = pend_w;
            e.fd   = (m_addr == DEPTH - 1);
            e.cyc  = c0 + LAT;
            exp_q.push_back(e);
            m_addr = (m_addr + 1) % DEPTH;
            pend_n = 0;
        end
    endtask

    task automatic model_clear();
        pend_w = 48'h0;
        pend_n = 0;
        m_addr = 0;
    endtask

    // Write monitor: every strobe must match the next expected write.
    exp_t mon_e;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (we_out) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_we", 64'(exp_q.size()), 64'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("wr_addr", 64'(addr_out), 64'(mon_e.addr));
                    check_val("wr_data", 64'(data_out), 64'(mon_e.data));
                    check_val("wr_fd", 64'(frame_done_out), 64'(mon_e.fd));
                    check_val("wr_latency", 64'(cyc), 64'(mon_e.cyc));
                    if (frame_done_out) fd_seen++;
                end
            end else if (frame_done_out) begin
                check_val("fd_without_we", 64'(we_out), 64'd1);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Drive one 8N1 frame; optional bad stop bit or clear_in at cycle clr_off.
    task automatic send_byte(input logic [7:0] b, input bit bad_stop, input int clr_off);
        int         c0;
        logic [9:0] fr;
        c0 = cyc;
        fr = {1'b1, b, 1'b0};
        if (!bad_stop) begin
            if (clr_off < 0) model_accept(b, c0);
            else             model_clear();
        end
        for (int t = 0; t < 10 * CPB; t++) begin
            if (bad_stop && t >= 9 * CPB) uart_rxd = (t >= 9 * CPB + 23);
            else                          uart_rxd = fr[t / CPB];
            clear_in = (t == clr_off);
            step();
        end
        uart_rxd = 1'b1;
        clear_in = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        check_val("pending_write", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic send_word_rand();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, -1);
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        step();
        clear_in = 1'b0;
        model_clear();
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_addr"}, 64'(addr_out), 64'd0);
        check_val({tag, "_data"}, 64'(data_out), 64'd0);
        check_val({tag, "_we"}, 64'(we_out), 64'd0);
        check_val({tag, "_fd"}, 64'(frame_done_out), 64'd0);
        check_val({tag, "_busy"}, 64'(busy_out), 64'd0);
        check_val({tag, "_err"}, 64'(error_out), 64'd0);
    endtask

    initial begin
        int         fd0;
        bit         saw_busy;
        logic [9:0] fr;

        repeat (3) step();
        check_all_zero("reset");
        rst_in = 1'b0;
        step();

        // Single word of 0x01..0x06, then a random word at the next address.
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0, -1);
        send_word_rand();

        // Fill to the end of the frame, expect one frame_done, then wrap.
        fd0 = fd_seen;
        while (m_addr != 0) send_word_rand();
        check_val("frame_done_count", 64'(fd_seen - fd0), 64'd1);
        send_word_rand();

        // Framing error: byte dropped, flag sticky until clear_in.
        send_byte(8'h5A, 1'b1, -1);
        check_val("err_set", 64'(error_out), 64'd1);
        for (int i = 0; i < 6; i++) send_byte(8'(8'hAA + i), 1'b0, -1);
        check_val("err_held", 64'(error_out), 64'd1);
        pulse_clear();
        check_val("err_cleared", 64'(error_out), 64'd0);
        check_val("clear_addr", 64'(addr_out), 64'd0);

        // Glitch: short low pulse makes the FSM busy but accepts nothing.
        saw_busy = 1'b0;
        uart_rxd = 1'b0;
        repeat (10) begin
            step();
            if (busy_out) saw_busy = 1'b1;
        end
        uart_rxd = 1'b1;
        repeat (40) begin
            step();
            if (busy_out) saw_busy = 1'b1;
        end
        check_val("glitch_busy_seen", 64'(saw_busy), 64'd1);
        check_val("glitch_idle", 64'(busy_out), 64'd0);
        check_val("glitch_no_err", 64'(error_out), 64'd0);

        // clear_in mid-word, then a fresh word 0x10..0x15 at address 0.
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, -1);
        pulse_clear();
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0, -1);

        // clear_in in the completion cycle suppresses the write.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b0, -1);
        send_byte(8'($urandom_range(0, 255)), 1'b0, LAT - 1);
        check_val("clr_win_addr", 64'(addr_out), 64'd0);
        send_word_rand();

        // Async reset during data bit 4 with address 5 and error set.
        while (m_addr != 5) send_word_rand();
        send_byte(8'h00, 1'b1, -1);
        check_val("pre_rst_addr", 64'(addr_out), 64'd5);
        check_val("pre_rst_err", 64'(error_out), 64'd1);
        fr = {1'b1, 8'($urandom_range(0, 255)), 1'b0};
        for (int t = 0; t < 5 * CPB + 10; t++) begin
            uart_rxd = fr[t / CPB];
            step();
        end
        check_val("pre_rst_busy", 64'(busy_out), 64'd1);
        rst_in = 1'b1;
        #1;
        check_all_zero("async_rst");
        uart_rxd = 1'b1;
        model_clear();
        repeat (3) step();
        rst_in = 1'b0;
        repeat (40) step();
        send_word_rand();

        repeat (5) step();
        check_val("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_bram_loader.md
# uart_bram_loader

UART receive-side counterpart to the disparity readout path. It deserializes 8N1 bytes from the host on `uart_rxd`, packs them into `BRAM_WIDTH`-bit words, and emits one write per word into a port of the left or right image BRAMs (48-bit words, 320×40 depth). A host can then stream new stereo frames into the design without re-synthesizing the `.mem` init files.

## Interface

Parameters:
- `CLK_FREQ`, default 100000000: system clock in Hz.
- `BAUD_RATE`, default 3000000: UART bit rate. `CLKS_PER_BIT` = `CLK_FREQ/BAUD_RATE`, integer-truncated, which gives 33.
- `BRAM_WIDTH`, default 48: word width. Must be a multiple of 8. `BYTES_PER_WORD` = `BRAM_WIDTH/8`, which gives 6.
- `BRAM_DEPTH`, default 12800: words per frame.

Ports:
- `clk_in`, in, 1: single system clock.
- `rst_in`, in, 1: asynchronous, active-high reset.
- `uart_rxd`, in, 1: asynchronous serial input. Idle level is high.
- `clear_in`, in, 1: synchronous pulse. Restarts word assembly and sets the address to 0.
- `addr_out`, out, `$clog2(BRAM_DEPTH)`: BRAM write address.
- `data_out`, out, `BRAM_WIDTH`: BRAM write data.
- `we_out`, out, 1: one-cycle write strobe.
- `frame_done_out`, out, 1: one-cycle pulse that coincides with the write to address `BRAM_DEPTH-1`.
- `busy_out`, out, 1: high while the receiver FSM is not in IDLE.
- `error_out`, out, 1: sticky framing-error flag.

## Operation

- **Input synchronizer.** `uart_rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All logic below uses the synchronized signal `rx_s`.
- **Receiver FSM: IDLE, START, DATA, STOP.**
  - IDLE: when `rx_s` is 0, go to START and clear the bit timer.
  - START: wait `CLKS_PER_BIT/2` cycles (16), then sample `rx_s`.
    - If it reads 1, treat the low pulse as a glitch and return to IDLE.
    - Otherwise go to DATA.
  - DATA: sample 8 bits, one every `CLKS_PER_BIT` cycles, LSB first, into the byte shift register.
  - STOP: after `CLKS_PER_BIT` cycles, sample `rx_s` and return to IDLE.
    - A 1 accepts the byte.
    - A 0 is a framing error: the byte is discarded and `error_out` is set to 1.
- **Word assembly.**
  - Each accepted byte shifts into the word register at the LSB end, so the first byte of a word lands in bits [`BRAM_WIDTH-1`:`BRAM_WIDTH-8`].
  - A byte counter runs from 0 to `BYTES_PER_WORD-1`. Discarded bytes do not advance it.
  - When the last byte of a word is accepted:
    - `data_out` is loaded with the full word.
    - `we_out` is asserted for exactly one cycle, with `addr_out` holding the current address.
    - The byte counter returns to 0.
- **Addressing.**
  - `addr_out` increments in the cycle after each `we_out`.
  - After address `BRAM_DEPTH-1`, it wraps to 0.
  - `frame_done_out` pulses in the same cycle as the write to `BRAM_DEPTH-1`.
- **`clear_in`.**
  - Sets the byte counter and `addr_out` to 0 and clears `error_out`.
  - Does not disturb a byte currently being received; that byte becomes byte 0 of the next word.
  - If `clear_in` and word completion occur in the same cycle, `clear_in` wins: no write is issued.
- **`error_out`** stays 1 until `clear_in` or `rst_in`.

## Timing

- **Reset values.** Asserting `rst_in` immediately drives `addr_out`, `data_out`, `we_out`, `frame_done_out`, `busy_out` and `error_out` to 0. The FSM returns to IDLE and the counters and shift registers go to 0. A reset mid-byte or mid-word abandons that partial data.
- **Sample points.** Bit sample points are taken relative to the first cycle in which `rx_s` is 0:
  - start bit at +16 cycles;
  - data bit k (k = 0..7) at +16+33·(k+1) cycles;
  - stop bit at +16+33·9 = +313 cycles.
- **Write latency.** `we_out` rises 1 cycle after the stop-bit sample, i.e. at cycle +314. Pin-to-`we_out` adds 2 cycles for the synchronizer.
- **Back-to-back bytes.** The FSM is back in IDLE by stop-bit centre + 1 cycle, so a start bit immediately following a stop bit is detected with no byte lost.
- **No backpressure.** The BRAM write port must accept a write on any cycle.

## Test plan

- **Single word.** Send bytes 0x01..0x06 at 3 Mbaud. Expect exactly one `we_out` pulse with `addr_out`=0 and `data_out`=0x010203040506. The following word is written at `addr_out`=1.
- **Full frame and wrap.** Send 12800×6 bytes with pattern data. Expect `frame_done_out` coincident with the write to address 12799. Then send 6 more bytes and expect a write at address 0.
- **Framing error.** Send one byte with stop bit = 0, then bytes 0xAA..0xAF. Expect `error_out`=1 and held, no write until the 6th good byte, then a single write with `data_out`=0xAAABACADAEAF. A subsequent `clear_in` pulse returns `error_out` to 0.
- **Glitch rejection.** Hold `uart_rxd` low for 10 cycles, then high. Expect `busy_out` to pulse, no byte accepted, and no `we_out`.
- **`clear_in` mid-word.** Send 3 bytes, pulse `clear_in`, then send 6 bytes 0x10..0x15. Expect one write with `addr_out`=0 and `data_out`=0x101112131415. Also assert `clear_in` in the completion cycle of a word and expect no write.
- **Async reset mid-byte.** Assert `rst_in` during data bit 4 while `addr_out`=5. Expect all outputs to be 0 without waiting for a clock edge. Then send 6 bytes and expect the write at `addr_out`=0.
